// File: rtl/sw_debounce_edge.sv
// Push-button conditioner: synchroniser, consecutive-sample debounce FSM and
// one-cycle press / release / long-press strobes for the ring counter stage.
module sw_debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sw_i,
  output logic sw_level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_press_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam bit                SINGLE    = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_PEND_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_PEND_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_s;

  state_t            r_state;
  state_t            w_state_next;
  logic [DB_W-1:0]   r_db_cnt;
  logic [DB_W-1:0]   w_db_next;
  logic              r_level;
  logic              w_level_next;
  logic              r_press;
  logic              w_press_next;
  logic              r_release;
  logic              w_release_next;

  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_long_fired;
  logic              r_long;
  logic              w_rise;
  logic              w_fall;
  logic              w_hold_en;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign w_sync_s = r_sync[SYNC_STAGES-1];

  // Any reversal of the synchronised input while pending restarts qualification.
  always_comb begin
    w_state_next   = r_state;
    w_db_next      = r_db_cnt;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    case (r_state)
      S_LOW: begin
        w_db_next = '0;
        if (w_sync_s) begin
          if (SINGLE) begin
            w_state_next = S_HIGH;
            w_press_next = 1'b1;
          end else begin
            w_state_next = S_PEND_HIGH;
            w_db_next    = DB_ONE;
          end
        end
      end
      S_PEND_HIGH: begin
        if (!w_sync_s) begin
          w_state_next = S_LOW;
          w_db_next    = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_next = S_HIGH;
          w_db_next    = '0;
          w_press_next = 1'b1;
        end else begin
          w_db_next = r_db_cnt + DB_ONE;
        end
      end
      S_HIGH: begin
        w_db_next = '0;
        if (!w_sync_s) begin
          if (SINGLE) begin
            w_state_next   = S_LOW;
            w_release_next = 1'b1;
          end else begin
            w_state_next = S_PEND_LOW;
            w_db_next    = DB_ONE;
          end
        end
      end
      S_PEND_LOW: begin
        if (w_sync_s) begin
          w_state_next = S_HIGH;
          w_db_next    = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_next   = S_LOW;
          w_db_next      = '0;
          w_release_next = 1'b1;
        end else begin
          w_db_next = r_db_cnt + DB_ONE;
        end
      end
      default: begin
        w_state_next = S_LOW;
        w_db_next    = '0;
      end
    endcase
  end

  assign w_level_next = (w_state_next == S_HIGH) || (w_state_next == S_PEND_LOW);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_LOW;
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_db_cnt  <= w_db_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
    end
  end

  // Counting only while the level stays high keeps long-press and release exclusive.
  assign w_rise    = w_level_next & ~r_level;
  assign w_fall    = ~w_level_next & r_level;
  assign w_hold_en = r_level & w_level_next & ~r_long_fired;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hold_cnt   <= '0;
      r_long_fired <= 1'b0;
      r_long       <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_rise) begin
        r_hold_cnt <= '0;
      end else if (w_hold_en) begin
        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
        if (r_hold_cnt == HOLD_LAST) begin
          r_long       <= 1'b1;
          r_long_fired <= 1'b1;
        end
      end
      if (w_fall) begin
        r_long_fired <= 1'b0;
      end
    end
  end

  assign sw_level_o      = r_level;
  assign press_pulse_o   = r_press;
  assign release_pulse_o = r_release;
  assign long_press_o    = r_long;

endmodule

// File: tb/tb_sw_debounce_edge.sv
// Bench for sw_debounce_edge: a run-length behavioural model checked every cycle,
// plus directed scenarios with hand-computed edge positions.
module tb_sw_debounce_edge;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b1;
  logic sw_i    = 1'b0;
  logic sw_level_o;
  logic press_pulse_o;
  logic release_pulse_o;
  logic long_press_o;

  int compared   = 0;
  int mismatched = 0;
  int longSeen   = 0;
  bit compareOn  = 1'b0;

  sw_debounce_edge #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .sw_i           (sw_i),
    .sw_level_o     (sw_level_o),
    .press_pulse_o  (press_pulse_o),
    .release_pulse_o(release_pulse_o),
    .long_press_o   (long_press_o)
  );

  always #20 clk_i = ~clk_i;

  // Model: the level flips once the delayed input has disagreed with it for DEB
  // consecutive samples; long press fires after HOLD further edges of steady high.
  bit [SYNC-1:0] mPipe    = '0;
  int            mRun     = 0;
  int            mHeld    = 0;
  bit            mFired   = 1'b0;
  bit            mLevel   = 1'b0;
  bit            mPress   = 1'b0;
  bit            mRelease = 1'b0;
  bit            mLong    = 1'b0;

  bit nSample, nLevel, nPress, nRelease, nLong, nFired;
  int nRun, nHeld;

  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mPipe    <= '0;
      mRun     <= 0;
      mHeld    <= 0;
      mFired   <= 1'b0;
      mLevel   <= 1'b0;
      mPress   <= 1'b0;
      mRelease <= 1'b0;
      mLong    <= 1'b0;
    end else begin
      nSample  = mPipe[SYNC-1];
      nLevel   = mLevel;
      nRun     = mRun;
      nHeld    = mHeld;
      nFired   = mFired;
      nPress   = 1'b0;
      nRelease = 1'b0;
      nLong    = 1'b0;
      if (nSample != nLevel) begin
        nRun = nRun + 1;
        if (nRun == DEB) begin
          nLevel   = nSample;
          nRun     = 0;
          nPress   = nSample;
          nRelease = !nSample;
        end
      end else begin
        nRun = 0;
      end
      if (nPress) begin
        nHeld = 0;
      end else if (mLevel && nLevel && !nFired) begin
        nHeld = nHeld + 1;
        if (nHeld == HOLD) begin
          nLong  = 1'b1;
          nFired = 1'b1;
        end
      end
      if (nRelease) nFired = 1'b0;
      mPipe    <= {mPipe[SYNC-2:0], sw_i};
      mRun     <= nRun;
      mHeld    <= nHeld;
      mFired   <= nFired;
      mLevel   <= nLevel;
      mPress   <= nPress;
      mRelease <= nRelease;
      mLong    <= nLong;
    end
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (compareOn) begin
      checkOutput("model sw_level_o", sw_level_o, mLevel);
      checkOutput("model press_pulse_o", press_pulse_o, mPress);
      checkOutput("model release_pulse_o", release_pulse_o, mRelease);
      checkOutput("model long_press_o", long_press_o, mLong);
      if (long_press_o) longSeen++;
    end
  end

  task automatic applyStimulus(input logic value);
    @(negedge clk_i);
    sw_i = value;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle(input int edges);
    repeat (edges) step();
  endtask

  // Edge k of the loop is E+k, where E first samples the press.
  task automatic longPressRun(input string tag);
    longSeen = 0;
    applyStimulus(1'b1);
    for (int k = 0; k <= 40; k++) begin
      step();
      if (k == 4)  checkOutput({tag, " level before rise"}, sw_level_o, 1'b0);
      if (k == 5)  checkOutput({tag, " press at E+5"}, press_pulse_o, 1'b1);
      if (k == 14) checkOutput({tag, " long before E+15"}, long_press_o, 1'b0);
      if (k == 15) checkOutput({tag, " long at E+15"}, long_press_o, 1'b1);
      if (k == 16) checkOutput({tag, " long one cycle"}, long_press_o, 1'b0);
      if (k == 34) checkOutput({tag, " level before release"}, sw_level_o, 1'b1);
      if (k == 35) checkOutput({tag, " release at F+5"}, release_pulse_o, 1'b1);
      if (k == 36) checkOutput({tag, " level after release"}, sw_level_o, 1'b0);
      if (k == 29) applyStimulus(1'b0);
    end
    checkCount({tag, " long pulse count"}, longSeen, 1);
  endtask

  initial begin
    #1;
    rst_n_i   = 1'b0;
    sw_i      = 1'b1;
    compareOn = 1'b1;
    settle(3);
    checkOutput("reset sw_level_o", sw_level_o, 1'b0);
    checkOutput("reset press_pulse_o", press_pulse_o, 1'b0);
    checkOutput("reset release_pulse_o", release_pulse_o, 1'b0);
    checkOutput("reset long_press_o", long_press_o, 1'b0);

    // Switch held through reset release: press on the 6th edge afterwards.
    @(negedge clk_i);
    rst_n_i = 1'b1;
    settle(5);
    checkOutput("post-reset press early", press_pulse_o, 1'b0);
    step();
    checkOutput("post-reset press", press_pulse_o, 1'b1);
    checkOutput("post-reset level", sw_level_o, 1'b1);
    step();
    checkOutput("post-reset press width", press_pulse_o, 1'b0);
    checkOutput("post-reset level held", sw_level_o, 1'b1);
    applyStimulus(1'b0);
    settle(12);
    checkOutput("post-reset released", sw_level_o, 1'b0);

    // Clean press.
    applyStimulus(1'b1);
    settle(5);
    checkOutput("clean level at E+4", sw_level_o, 1'b0);
    step();
    checkOutput("clean press at E+5", press_pulse_o, 1'b1);
    checkOutput("clean level at E+5", sw_level_o, 1'b1);
    step();
    checkOutput("clean press width", press_pulse_o, 1'b0);
    applyStimulus(1'b0);
    settle(12);
    checkOutput("clean released", sw_level_o, 1'b0);

    // Bounce 1,0,1 at E, E+2, E+3.
    applyStimulus(1'b1);
    step();
    step();
    applyStimulus(1'b0);
    step();
    applyStimulus(1'b1);
    for (int k = 3; k <= 7; k++) begin
      step();
      checkOutput("bounce no early press", press_pulse_o, 1'b0);
    end
    step();
    checkOutput("bounce press at E+8", press_pulse_o, 1'b1);
    step();
    checkOutput("bounce single press", press_pulse_o, 1'b0);
    applyStimulus(1'b0);
    settle(12);

    // Two-cycle glitch is rejected.
    applyStimulus(1'b1);
    step();
    step();
    applyStimulus(1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("glitch level", sw_level_o, 1'b0);
      checkOutput("glitch press", press_pulse_o, 1'b0);
    end

    longPressRun("long1");
    longPressRun("long2");

    // Reset while PEND_LOW: level drops at once, no release strobe.
    applyStimulus(1'b1);
    settle(8);
    checkOutput("midreset pressed", sw_level_o, 1'b1);
    applyStimulus(1'b0);
    settle(4);
    checkOutput("midreset pend_low level", sw_level_o, 1'b1);
    #5;
    rst_n_i = 1'b0;
    #1;
    checkOutput("midreset async level", sw_level_o, 1'b0);
    checkOutput("midreset no release", release_pulse_o, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("midreset held release", release_pulse_o, 1'b0);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checkOutput("after midreset level", sw_level_o, 1'b0);
      checkOutput("after midreset release", release_pulse_o, 1'b0);
    end

    compareOn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
